// File: rtl/adder_result_fifo.sv
// Capture FIFO for the pipelined split adder: buffers {carry, sum} results
// first-word-fall-through and keeps carry-out and overflow-drop statistics.
module adder_result_fifo #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 16
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     clr,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_sum,
  input  logic                     in_c,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_sum,
  output logic                     out_c,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         carry_cnt,
  output logic [CNT_W-1:0]         drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DATA_W:0]   mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              rd;
  logic              wr;
  logic              drop;
  logic [DATA_W:0]   head;

  // Handshake: a head entry transfers on any edge where out_valid and
  // out_ready are both high; the input side has no ready and is never stalled,
  // so a result arriving while full is dropped unless a read frees a slot.
  assign out_valid = (level != '0);
  assign full      = (level == LW'(DEPTH));
  assign rd        = out_valid & out_ready;
  assign wr        = in_valid & (~full | rd);
  assign drop      = in_valid & full & ~rd;

  assign head    = mem[rd_ptr];
  assign out_sum = out_valid ? head[DATA_W-1:0] : '0;
  assign out_c   = out_valid ? head[DATA_W]     : 1'b0;

  // Storage is deliberately left out of reset; only the pointers define content.
  always_ff @(posedge CLK) begin
    if (wr && !clr) begin
      mem[wr_ptr] <= {in_c, in_sum};
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      carry_cnt <= '0;
      drop_cnt  <= '0;
    end else if (clr) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      carry_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      if (wr) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (wr && !rd) begin
        level <= level + LW'(1);
      end else if (rd && !wr) begin
        level <= level - LW'(1);
      end
      if (wr && in_c && (carry_cnt != '1)) begin
        carry_cnt <= carry_cnt + CNT_W'(1);
      end
      if (drop && (drop_cnt != '1)) begin
        drop_cnt <= drop_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_adder_result_fifo.sv
// Directed bench for adder_result_fifo: vector table for fill/overflow/drain,
// hand-written sequences for reset, clear, latency and counter saturation.
module tb_adder_result_fifo;

  localparam int DEPTH = 8;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic [63:0] in_sum = '0;
  logic        in_c = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_sum;
  logic        out_c;
  logic        full;
  logic [3:0]  level;
  logic [15:0] carry_cnt;
  logic [15:0] drop_cnt;

  // Small instance used only to reach counter saturation quickly.
  logic        in_valid2 = 1'b0;
  logic        out_ready2 = 1'b0;
  logic        out_valid2;
  logic [63:0] out_sum2;
  logic        out_c2;
  logic        full2;
  logic [1:0]  level2;
  logic [2:0]  carry_cnt2;
  logic [2:0]  drop_cnt2;

  adder_result_fifo #(.DATA_W(64), .DEPTH(DEPTH), .CNT_W(16)) dut (
    .CLK(CLK), .RST(RST), .clr(clr), .in_valid(in_valid), .in_sum(in_sum),
    .in_c(in_c), .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_c(out_c), .full(full), .level(level), .carry_cnt(carry_cnt),
    .drop_cnt(drop_cnt)
  );

  adder_result_fifo #(.DATA_W(64), .DEPTH(2), .CNT_W(3)) dut_small (
    .CLK(CLK), .RST(RST), .clr(clr), .in_valid(in_valid2), .in_sum(in_sum),
    .in_c(in_c), .out_valid(out_valid2), .out_ready(out_ready2), .out_sum(out_sum2),
    .out_c(out_c2), .full(full2), .level(level2), .carry_cnt(carry_cnt2),
    .drop_cnt(drop_cnt2)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad = 0;
  logic [64:0] exp_q[$];
  int mlev = 0;

  typedef struct {
    logic        v;
    logic [63:0] a;
    logic [63:0] b;
    logic        rdy;
    logic [3:0]  exp_level;
    logic        exp_full;
    logic [15:0] exp_drop;
  } vec_t;

  vec_t vecs[19];

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // One clock: drive the result of a+b, check the head against the
  // scoreboard when a read happens, then advance past the edge.
  task automatic cycle(input logic v, input logic [63:0] a, input logic [63:0] b,
                       input logic rdy);
    logic [64:0] r;
    logic [64:0] e;
    logic        mrd;
    logic        mwr;
    r = {1'b0, a} + {1'b0, b};
    in_valid = v;
    in_sum = r[63:0];
    in_c = r[64];
    out_ready = rdy;
    mrd = (mlev != 0) && rdy;
    mwr = v && ((mlev != DEPTH) || mrd);
    check("out_valid", {127'd0, out_valid}, {127'd0, (mlev != 0)});
    if (mlev == 0) begin
      check("empty_out", {63'd0, out_c, out_sum}, 128'd0);
    end
    if (mrd) begin
      if (exp_q.size() == 0) begin
        check("sb_underflow", 128'd1, 128'd0);
      end else begin
        e = exp_q.pop_front();
        check("drain_data", {63'd0, out_c, out_sum}, {63'd0, e});
      end
    end
    if (mwr) exp_q.push_back(r);
    if (mwr && !mrd) mlev++;
    else if (mrd && !mwr) mlev--;
    @(posedge CLK);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic drain_all();
    int n;
    n = mlev;
    for (int i = 0; i < n; i++) cycle(1'b0, 64'd0, 64'd0, 1'b1);
    check("drain_empty", {124'd0, level}, 128'd0);
    check("drain_sb", exp_q.size(), 0);
  endtask

  initial begin
    for (int i = 0; i < 10; i++) begin
      vecs[i].v = 1'b1;
      vecs[i].a = 64'(i + 1);
      vecs[i].b = 64'd0;
      vecs[i].rdy = 1'b0;
      vecs[i].exp_level = (i < 8) ? 4'(i + 1) : 4'd8;
      vecs[i].exp_full = (i >= 7);
      vecs[i].exp_drop = (i < 8) ? 16'd0 : 16'(i - 7);
    end
    vecs[10] = '{v: 1'b1, a: 64'h100, b: 64'h23, rdy: 1'b1,
                 exp_level: 4'd8, exp_full: 1'b1, exp_drop: 16'd2};
    for (int i = 0; i < 8; i++) begin
      vecs[11 + i].v = 1'b0;
      vecs[11 + i].a = 64'd0;
      vecs[11 + i].b = 64'd0;
      vecs[11 + i].rdy = 1'b1;
      vecs[11 + i].exp_level = 4'(7 - i);
      vecs[11 + i].exp_full = 1'b0;
      vecs[11 + i].exp_drop = 16'd2;
    end

    // Reset held with input activity: nothing is captured.
    RST = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = i[0];
      in_sum = 64'hDEAD_0000 + 64'(i);
      @(posedge CLK);
      #1;
      check("rst_valid", {127'd0, out_valid}, 128'd0);
      check("rst_level", {124'd0, level}, 128'd0);
      check("rst_sum", {64'd0, out_sum}, 128'd0);
      check("rst_cnt", {96'd0, carry_cnt, drop_cnt}, 128'd0);
    end
    check("rst_full", {127'd0, full}, 128'd0);
    in_valid = 1'b0;
    RST = 1'b0;

    // Latency and ordering.
    cycle(1'b1, 64'h1, 64'h0, 1'b0);
    check("lat_valid", {127'd0, out_valid}, 128'd1);
    check("lat_head", {64'd0, out_sum}, 128'h1);
    cycle(1'b1, 64'h2, 64'h0, 1'b0);
    cycle(1'b1, 64'h3, 64'h0, 1'b0);
    check("order_level", {124'd0, level}, 128'd3);
    drain_all();

    // Fill, overflow, full read+write, drain.
    for (int i = 0; i < 19; i++) begin
      cycle(vecs[i].v, vecs[i].a, vecs[i].b, vecs[i].rdy);
      check($sformatf("vec%0d_level", i), {124'd0, level}, {124'd0, vecs[i].exp_level});
      check($sformatf("vec%0d_full", i), {127'd0, full}, {127'd0, vecs[i].exp_full});
      check($sformatf("vec%0d_drop", i), {112'd0, drop_cnt}, {112'd0, vecs[i].exp_drop});
    end
    check("ovf_sb", exp_q.size(), 0);

    // Carry statistics with continuous draining.
    for (int i = 0; i < 3; i++) cycle(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    for (int i = 0; i < 2; i++) cycle(1'b1, 64'h5, 64'h6, 1'b1);
    check("carry_cnt", {112'd0, carry_cnt}, 128'd3);
    drain_all();

    // Saturation on the narrow-counter instance.
    in_c = 1'b1;
    in_sum = 64'h77;
    in_valid2 = 1'b1;
    out_ready2 = 1'b1;
    repeat (9) @(posedge CLK);
    #1;
    check("sat_carry", {125'd0, carry_cnt2}, 128'd7);
    check("sat_level_rw", {126'd0, level2}, 128'd1);
    out_ready2 = 1'b0;
    in_c = 1'b0;
    repeat (10) @(posedge CLK);
    #1;
    check("sat_drop", {125'd0, drop_cnt2}, 128'd7);
    check("sat_full", {126'd0, full2, level2}, {126'd0, 1'b1, 2'd2});
    check("sat_head", {63'd0, out_c2, out_sum2}, {63'd0, 1'b1, 64'h77});
    in_valid2 = 1'b0;

    // Synchronous clear at level 5 beats a same-cycle write.
    for (int i = 0; i < 5; i++) cycle(1'b1, 64'(i + 20), 64'd0, 1'b0);
    check("pre_clr_level", {124'd0, level}, 128'd5);
    clr = 1'b1;
    in_valid = 1'b1;
    in_sum = 64'h55;
    in_c = 1'b1;
    @(posedge CLK);
    #1;
    clr = 1'b0;
    in_valid = 1'b0;
    check("clr_level", {124'd0, level}, 128'd0);
    check("clr_valid", {127'd0, out_valid, 64'd0}, 128'd0);
    check("clr_cnt", {96'd0, carry_cnt, drop_cnt}, 128'd0);
    check("clr_small", {123'd0, level2, carry_cnt2}, 128'd0);
    exp_q.delete();
    mlev = 0;

    // Asynchronous reset between edges discards everything at once.
    for (int i = 0; i < 5; i++) cycle(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'(i + 1), 1'b0);
    check("pre_rst_carry", {112'd0, carry_cnt}, 128'd5);
    #2;
    RST = 1'b1;
    #1;
    check("arst_level", {124'd0, level}, 128'd0);
    check("arst_valid", {127'd0, out_valid}, 128'd0);
    check("arst_cnt", {96'd0, carry_cnt, drop_cnt}, 128'd0);
    #1;
    RST = 1'b0;
    exp_q.delete();
    mlev = 0;
    @(posedge CLK);
    #1;
    cycle(1'b1, 64'hABCD, 64'h1111, 1'b0);
    cycle(1'b1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0001, 1'b0);
    check("post_rst_level", {124'd0, level}, 128'd2);
    drain_all();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
